// File: rtl/debug_run_ctrl_if.sv
// debug_run_ctrl_if: bundles the UART-RX, pipeline, dump-unit and program-memory
// signals of the debug run controller.
//   master : the controller side (drives O_*, samples I_*)
//   slave  : the environment side (drives I_*, samples O_*)
// Ports carried:
//   I_RX_DATA/I_RX_EMPTY/O_RD_UART        show-ahead RX FIFO head and pop strobe
//   I_HALT/O_CPU_EN/O_ITERACIONES         pipeline halt, clock enable, cycle count
//   I_DUMP_DONE/O_DUMP_REQ                dump unit handshake
//   O_PROG_WE/O_PROG_ADDR/O_PROG_DATA     program-memory write port
//   O_TIMEOUT                             sticky run-watchdog flag
interface debug_run_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic [7:0]        I_RX_DATA;
    logic              I_RX_EMPTY;
    logic              O_RD_UART;
    logic              I_HALT;
    logic              I_DUMP_DONE;
    logic              O_DUMP_REQ;
    logic              O_CPU_EN;
    logic              O_PROG_WE;
    logic [ADDR_W-1:0] O_PROG_ADDR;
    logic [31:0]       O_PROG_DATA;
    logic [31:0]       O_ITERACIONES;
    logic              O_TIMEOUT;

    modport master (
        input  I_RX_DATA, I_RX_EMPTY, I_HALT, I_DUMP_DONE,
        output O_RD_UART, O_DUMP_REQ, O_CPU_EN, O_PROG_WE, O_PROG_ADDR,
               O_PROG_DATA, O_ITERACIONES, O_TIMEOUT
    );

    modport slave (
        output I_RX_DATA, I_RX_EMPTY, I_HALT, I_DUMP_DONE,
        input  O_RD_UART, O_DUMP_REQ, O_CPU_EN, O_PROG_WE, O_PROG_ADDR,
               O_PROG_DATA, O_ITERACIONES, O_TIMEOUT
    );
endinterface

// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl: host command controller between the UART RX FIFO and the CPU.
// Decodes 'L' (load program words MSB-first until HALT_WORD or last address),
// 'C' (run until I_HALT) and 'S' (single step), then requests a state dump and
// waits for it to finish. Owns the CPU clock enable and the executed-cycle count.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-low reset
//   bus    debug_run_ctrl_if.master (RX FIFO, pipeline, dump unit, program memory)
// Optional feature: define DEBUG_TIMEOUT_EN to add a run watchdog of
// TIMEOUT_CYCLES enabled cycles that sets the sticky O_TIMEOUT flag.
// O_RD_UART and O_CPU_EN are combinational; the other strobes decode the state.
module debug_run_ctrl #(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [7:0]  CMD_LOAD  = 8'h4C,
    parameter logic [7:0]  CMD_CONT  = 8'h43,
    parameter logic [7:0]  CMD_STEP  = 8'h53
`ifdef DEBUG_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
`endif
) (
    input  logic             CLK,
    input  logic             RESET,
    debug_run_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WR,
        S_RUN,
        S_STEP,
        S_DUMP_REQ,
        S_DUMP_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       word_q;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       iter_q;

    logic rd_c, cpu_en_c, we_c, dump_req_c;
    logic load_start, byte_take, addr_inc;
`ifdef DEBUG_TIMEOUT_EN
    logic        run_start, to_hit;
    logic [31:0] run_cnt_q;
    logic        timeout_q;
`endif

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d    = state_q;
        rd_c       = 1'b0;
        cpu_en_c   = 1'b0;
        we_c       = 1'b0;
        dump_req_c = 1'b0;
        load_start = 1'b0;
        byte_take  = 1'b0;
        addr_inc   = 1'b0;
`ifdef DEBUG_TIMEOUT_EN
        run_start  = 1'b0;
        to_hit     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!bus.I_RX_EMPTY) begin
                    rd_c = 1'b1;
                    case (bus.I_RX_DATA)
                        CMD_LOAD: begin
                            state_d    = S_LOAD;
                            load_start = 1'b1;
                        end
                        CMD_CONT: begin
                            state_d = S_RUN;
`ifdef DEBUG_TIMEOUT_EN
                            run_start = 1'b1;
`endif
                        end
                        CMD_STEP: state_d = S_STEP;
                        default:  state_d = S_IDLE;
                    endcase
                end
            end
            S_LOAD: begin
                if (!bus.I_RX_EMPTY) begin
                    rd_c      = 1'b1;
                    byte_take = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_LOAD_WR;
                    end
                end
            end
            S_LOAD_WR: begin
                we_c = 1'b1;
                // The last address ends the load so the address never wraps
                if (word_q == HALT_WORD || addr_q == '1) begin
                    state_d = S_IDLE;
                end else begin
                    addr_inc = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_RUN: begin
                cpu_en_c = !bus.I_HALT;
                if (bus.I_HALT) begin
                    state_d = S_DUMP_REQ;
                end
`ifdef DEBUG_TIMEOUT_EN
                // Leave on the enabled cycle that brings the count to the limit
                else if (run_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    to_hit  = 1'b1;
                    state_d = S_DUMP_REQ;
                end
`endif
            end
            S_STEP: begin
                cpu_en_c = !bus.I_HALT;
                state_d  = S_DUMP_REQ;
            end
            S_DUMP_REQ: begin
                dump_req_c = 1'b1;
                state_d    = S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                if (bus.I_DUMP_DONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Load datapath and executed-cycle counter
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_q     <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            iter_q     <= '0;
        end else begin
            if (load_start) begin
                addr_q     <= '0;
                byte_cnt_q <= '0;
            end else begin
                if (byte_take) begin
                    word_q     <= {word_q[23:0], bus.I_RX_DATA};
                    byte_cnt_q <= byte_cnt_q + 2'd1;
                end
                if (addr_inc) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            if (cpu_en_c) begin
                iter_q <= iter_q + 32'd1;
            end
        end
    end

`ifdef DEBUG_TIMEOUT_EN
    // Run watchdog: counts enabled RUN cycles, flag sticky until next load
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            run_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (run_start) begin
                run_cnt_q <= '0;
            end else if (cpu_en_c && state_q == S_RUN) begin
                run_cnt_q <= run_cnt_q + 32'd1;
            end
            if (load_start) begin
                timeout_q <= 1'b0;
            end else if (to_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.O_TIMEOUT = timeout_q;
`else
    assign bus.O_TIMEOUT = 1'b0;
`endif

    // Pop is held off while reset is asserted so every output reads 0
    assign bus.O_RD_UART     = rd_c & RESET;
    assign bus.O_CPU_EN      = cpu_en_c;
    assign bus.O_PROG_WE     = we_c;
    assign bus.O_DUMP_REQ    = dump_req_c;
    assign bus.O_PROG_ADDR   = addr_q;
    assign bus.O_PROG_DATA   = word_q;
    assign bus.O_ITERACIONES = iter_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// tb_debug_run_ctrl: self-checking bench for debug_run_ctrl. A show-ahead FIFO
// model feeds command bytes; a negedge monitor counts pops, enables, dump
// requests and program writes; each scenario task compares against a
// reference built from the command rules (load word list, cycle totals).
module tb_debug_run_ctrl;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned MAX_ADDR = (1 << ADDR_W) - 1;
    localparam logic [7:0]  CMD_LOAD = 8'h4C;
    localparam logic [7:0]  CMD_CONT = 8'h43;
    localparam logic [7:0]  CMD_STEP = 8'h53;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    debug_run_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DEBUG_TIMEOUT_EN
    localparam int unsigned TO_CYC = 16;
    debug_run_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(32'(TO_CYC))) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus.master));
`else
    debug_run_ctrl #(.ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus.master));
`endif

    always #5 CLK = ~CLK;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_iter = 32'd0;

    // FIFO model: append-only byte list; head = pops seen + flush offset
    logic [7:0]  fifo[$];
    int          skip = 0;

    // Monitor results
    int unsigned n_pop  = 0;
    int unsigned n_en   = 0;
    int unsigned n_dump = 0;
    int unsigned got_addr[$];
    logic [31:0] got_data[$];

    // Reference load results
    int unsigned exp_addr[$];
    logic [31:0] exp_data[$];

    always @(negedge CLK) begin
        if (bus.O_RD_UART === 1'b1) n_pop++;
        if (bus.O_CPU_EN === 1'b1) n_en++;
        if (bus.O_DUMP_REQ === 1'b1) n_dump++;
        if (bus.O_PROG_WE === 1'b1) begin
            got_addr.push_back(int'(bus.O_PROG_ADDR));
            got_data.push_back(bus.O_PROG_DATA);
        end
    end

    always @(posedge CLK) begin
        int head;
        #1;
        head = int'(n_pop) + skip;
        if (head < fifo.size()) begin
            bus.I_RX_DATA  = fifo[head];
            bus.I_RX_EMPTY = 1'b0;
        end else begin
            bus.I_RX_DATA  = 8'h00;
            bus.I_RX_EMPTY = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // sel: 0 = pops, 1 = CPU enables, other = dump requests
    task automatic wait_cnt(input int sel, input int unsigned target, output bit ok);
        int unsigned cur;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            case (sel)
                0:       cur = n_pop;
                1:       cur = n_en;
                default: cur = n_dump;
            endcase
            if (cur >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_done();
        tick();
        bus.I_DUMP_DONE = 1'b1;
        tick();
        bus.I_DUMP_DONE = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] b[$], output int unsigned w0,
                           output int unsigned p0, output bit ok);
        w0 = got_data.size();
        p0 = n_pop;
        fifo.push_back(CMD_LOAD);
        foreach (b[i]) fifo.push_back(b[i]);
        wait_cnt(0, p0 + 1 + b.size(), ok);
        repeat (4) tick();
    endtask

    // Word list a load byte stream should produce
    function automatic void model_load(input logic [7:0] b[$]);
        int unsigned a;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        a = 0;
        for (int i = 0; i + 3 < b.size(); i += 4) begin
            w = {b[i], b[i+1], b[i+2], b[i+3]};
            exp_addr.push_back(a);
            exp_data.push_back(w);
            if (w == 32'hFFFF_FFFF || a == MAX_ADDR) break;
            a++;
        end
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom();
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        return w;
    endfunction

    task automatic test_reset();
        bus.I_HALT      = 1'b0;
        bus.I_DUMP_DONE = 1'b0;
        RESET           = 1'b0;
        repeat (3) tick();
        checks++; if (bus.O_RD_UART !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", bus.O_RD_UART); end
        checks++; if (bus.O_CPU_EN !== 1'b0) begin failures++; $display("FAIL reset_cpu_en got=%b exp=0", bus.O_CPU_EN); end
        checks++; if (bus.O_DUMP_REQ !== 1'b0) begin failures++; $display("FAIL reset_dump_req got=%b exp=0", bus.O_DUMP_REQ); end
        checks++; if (bus.O_PROG_WE !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.O_PROG_WE); end
        checks++; if (bus.O_PROG_ADDR !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.O_PROG_ADDR); end
        checks++; if (bus.O_PROG_DATA !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.O_PROG_DATA); end
        checks++; if (bus.O_ITERACIONES !== 32'h0) begin failures++; $display("FAIL reset_iter got=%h exp=0", bus.O_ITERACIONES); end
        checks++; if (bus.O_TIMEOUT !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", bus.O_TIMEOUT); end
        RESET = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_load();
        logic [7:0] b[$];
        int unsigned w0, p0;
        bit ok;
        b = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_load(b);
        do_load(b, w0, p0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL load_dir_wait got=timeout exp=9 pops"); end
        checks++; if (n_pop - p0 != 9) begin failures++; $display("FAIL load_dir_pops got=%0d exp=9", n_pop - p0); end
        checks++; if (got_data.size() - w0 != exp_data.size()) begin failures++; $display("FAIL load_dir_count got=%0d exp=%0d", got_data.size() - w0, exp_data.size()); end
        for (int i = 0; i < exp_data.size(); i++) begin
            checks++;
            if (w0 + i >= got_data.size() || got_addr[w0+i] != exp_addr[i] || got_data[w0+i] !== exp_data[i]) begin
                failures++;
                $display("FAIL load_dir_word%0d got=%0d:%h exp=%0d:%h", i, got_addr[w0+i], got_data[w0+i], exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_load_random();
        logic [7:0] b[$];
        logic [31:0] w;
        int unsigned w0, p0, nw;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            b.delete();
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                w = rand_word();
                b.push_back(w[31:24]); b.push_back(w[23:16]); b.push_back(w[15:8]); b.push_back(w[7:0]);
            end
            repeat (4) b.push_back(8'hFF);
            model_load(b);
            do_load(b, w0, p0, ok);
            checks++; if (!ok) begin failures++; $display("FAIL load_rnd_wait run=%0d got=timeout", r); end
            checks++; if (got_data.size() - w0 != exp_data.size()) begin failures++; $display("FAIL load_rnd_count run=%0d got=%0d exp=%0d", r, got_data.size() - w0, exp_data.size()); end
            for (int i = 0; i < exp_data.size(); i++) begin
                checks++;
                if (w0 + i >= got_data.size() || got_addr[w0+i] != exp_addr[i] || got_data[w0+i] !== exp_data[i]) begin
                    failures++;
                    $display("FAIL load_rnd_word run=%0d idx=%0d got=%0d:%h exp=%0d:%h", r, i, got_addr[w0+i], got_data[w0+i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic test_cont();
        int unsigned lens[4];
        int unsigned e0, d0, p0, hold;
        bit ok;
        lens[0] = 37;
        for (int i = 1; i < 4; i++) lens[i] = $urandom_range(1, 60);
`ifdef DEBUG_TIMEOUT_EN
        for (int i = 0; i < 4; i++) if (lens[i] >= TO_CYC) lens[i] = TO_CYC - 1;
`endif
        for (int r = 0; r < 4; r++) begin
            e0 = n_en; d0 = n_dump; p0 = n_pop;
            fifo.push_back(CMD_CONT);
            wait_cnt(1, e0 + lens[r], ok);
            bus.I_HALT = 1'b1;
            checks++; if (!ok) begin failures++; $display("FAIL cont_en_wait run=%0d got=%0d exp=%0d", r, n_en - e0, lens[r]); end
            wait_cnt(2, d0 + 1, ok);
            checks++; if (!ok) begin failures++; $display("FAIL cont_dump_wait run=%0d got=timeout exp=dump_req", r); end
            exp_iter += 32'(lens[r]);
            fifo.push_back(8'h7A);
            hold = $urandom_range(3, 10);
            repeat (hold) tick();
            checks++; if (n_en - e0 != lens[r]) begin failures++; $display("FAIL cont_en_count run=%0d got=%0d exp=%0d", r, n_en - e0, lens[r]); end
            checks++; if (n_dump - d0 != 1) begin failures++; $display("FAIL cont_dump_count run=%0d got=%0d exp=1", r, n_dump - d0); end
            checks++; if (n_pop - p0 != 1) begin failures++; $display("FAIL cont_pop_in_dump run=%0d got=%0d exp=1", r, n_pop - p0); end
            checks++; if (bus.O_ITERACIONES !== exp_iter) begin failures++; $display("FAIL cont_iter run=%0d got=%0d exp=%0d", r, bus.O_ITERACIONES, exp_iter); end
            checks++; if (bus.O_TIMEOUT !== 1'b0) begin failures++; $display("FAIL cont_timeout run=%0d got=%b exp=0", r, bus.O_TIMEOUT); end
            pulse_done();
            bus.I_HALT = 1'b0;
            wait_cnt(0, p0 + 2, ok);
            checks++; if (!ok) begin failures++; $display("FAIL cont_pop_after_done run=%0d got=%0d exp=2", r, n_pop - p0); end
            repeat (2) tick();
        end
    endtask

    task automatic test_step();
        int unsigned e0, d0, p0;
        bit ok;
        e0 = n_en; d0 = n_dump; p0 = n_pop;
        fifo.push_back(CMD_STEP); fifo.push_back(CMD_STEP); fifo.push_back(CMD_STEP);
        for (int i = 0; i < 3; i++) begin
            wait_cnt(2, d0 + i + 1, ok);
            checks++; if (!ok) begin failures++; $display("FAIL step_dump_wait step=%0d got=timeout exp=dump_req", i); end
            repeat ($urandom_range(1, 5)) tick();
            checks++; if (n_pop - p0 != i + 1) begin failures++; $display("FAIL step_pops step=%0d got=%0d exp=%0d", i, n_pop - p0, i + 1); end
            checks++; if (n_en - e0 != i + 1) begin failures++; $display("FAIL step_en step=%0d got=%0d exp=%0d", i, n_en - e0, i + 1); end
            pulse_done();
        end
        repeat (3) tick();
        exp_iter += 32'd3;
        checks++; if (n_dump - d0 != 3) begin failures++; $display("FAIL step_dump_count got=%0d exp=3", n_dump - d0); end
        checks++; if (bus.O_ITERACIONES !== exp_iter) begin failures++; $display("FAIL step_iter got=%0d exp=%0d", bus.O_ITERACIONES, exp_iter); end
    endtask

    task automatic test_halted();
        int unsigned e0, d0, p0, w0;
        bit ok;
        bus.I_HALT = 1'b1;
        tick();
        e0 = n_en; d0 = n_dump; w0 = got_data.size();
        fifo.push_back(CMD_STEP); fifo.push_back(CMD_CONT);
        for (int i = 0; i < 2; i++) begin
            wait_cnt(2, d0 + i + 1, ok);
            checks++; if (!ok) begin failures++; $display("FAIL halted_dump_wait cmd=%0d got=timeout exp=dump_req", i); end
            pulse_done();
        end
        repeat (3) tick();
        checks++; if (n_en != e0) begin failures++; $display("FAIL halted_en got=%0d exp=0", n_en - e0); end
        checks++; if (n_dump - d0 != 2) begin failures++; $display("FAIL halted_dumps got=%0d exp=2", n_dump - d0); end
        checks++; if (bus.O_ITERACIONES !== exp_iter) begin failures++; $display("FAIL halted_iter got=%0d exp=%0d", bus.O_ITERACIONES, exp_iter); end
        p0 = n_pop; d0 = n_dump;
        fifo.push_back(8'h7A);
        wait_cnt(0, p0 + 1, ok);
        repeat (5) tick();
        checks++; if (!ok) begin failures++; $display("FAIL unknown_pop got=%0d exp=1", n_pop - p0); end
        checks++; if (n_dump != d0 || n_en != e0 || got_data.size() != w0) begin failures++; $display("FAIL unknown_response got=dump%0d/en%0d/we%0d exp=0/0/0", n_dump - d0, n_en - e0, got_data.size() - w0); end
        bus.I_HALT = 1'b0;
    endtask

    task automatic test_load_max();
        logic [7:0] b[$];
        logic [31:0] w;
        int unsigned w0, p0, d0, bad;
        bit ok;
        for (int k = 0; k <= MAX_ADDR; k++) begin
            w = rand_word();
            b.push_back(w[31:24]); b.push_back(w[23:16]); b.push_back(w[15:8]); b.push_back(w[7:0]);
        end
        model_load(b);
        do_load(b, w0, p0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL load_max_wait got=%0d exp=%0d pops", n_pop - p0, b.size() + 1); end
        checks++; if (got_data.size() - w0 != exp_data.size()) begin failures++; $display("FAIL load_max_count got=%0d exp=%0d", got_data.size() - w0, exp_data.size()); end
        bad = 0;
        for (int i = 0; i < exp_data.size(); i++) begin
            if (w0 + i >= got_data.size() || got_addr[w0+i] != exp_addr[i] || got_data[w0+i] !== exp_data[i]) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL load_max_words got=%0d wrong exp=0 wrong", bad); end
        // After the last address the controller must be back to decoding commands
        d0 = n_dump;
        fifo.push_back(CMD_STEP);
        wait_cnt(2, d0 + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL load_max_idle got=no_dump exp=dump_req"); end
        pulse_done();
        repeat (2) tick();
        exp_iter += 32'd1;
        checks++; if (bus.O_ITERACIONES !== exp_iter) begin failures++; $display("FAIL load_max_iter got=%0d exp=%0d", bus.O_ITERACIONES, exp_iter); end
    endtask

    task automatic test_reset_midload();
        logic [7:0] b[$];
        logic [31:0] w;
        int unsigned w0, p0;
        bit ok;
        w0 = got_data.size(); p0 = n_pop;
        fifo.push_back(CMD_LOAD);
        for (int k = 0; k < 4; k++) fifo.push_back(8'($urandom()));
        wait_cnt(0, p0 + 3, ok);
        RESET = 1'b0;
        skip = fifo.size() - int'(n_pop);
        checks++; if (!ok) begin failures++; $display("FAIL midload_wait got=%0d exp=3 pops", n_pop - p0); end
        tick();
        checks++; if (bus.O_RD_UART !== 1'b0 || bus.O_PROG_WE !== 1'b0 || bus.O_CPU_EN !== 1'b0 || bus.O_DUMP_REQ !== 1'b0) begin failures++; $display("FAIL midload_strobes got=%b%b%b%b exp=0000", bus.O_RD_UART, bus.O_PROG_WE, bus.O_CPU_EN, bus.O_DUMP_REQ); end
        checks++; if (bus.O_PROG_ADDR !== '0 || bus.O_PROG_DATA !== 32'h0) begin failures++; $display("FAIL midload_prog got=%h:%h exp=0:0", bus.O_PROG_ADDR, bus.O_PROG_DATA); end
        checks++; if (bus.O_ITERACIONES !== 32'h0) begin failures++; $display("FAIL midload_iter got=%0d exp=0", bus.O_ITERACIONES); end
        repeat (3) tick();
        checks++; if (got_data.size() != w0) begin failures++; $display("FAIL midload_we got=%0d exp=0", got_data.size() - w0); end
        RESET = 1'b1;
        exp_iter = 32'd0;
        repeat (2) tick();
        w = rand_word();
        b = '{w[31:24], w[23:16], w[15:8], w[7:0], 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_load(b);
        do_load(b, w0, p0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL reload_wait got=%0d exp=9 pops", n_pop - p0); end
        checks++; if (got_data.size() - w0 != exp_data.size()) begin failures++; $display("FAIL reload_count got=%0d exp=%0d", got_data.size() - w0, exp_data.size()); end
        checks++; if (w0 >= got_data.size() || got_addr[w0] != exp_addr[0] || got_data[w0] !== exp_data[0]) begin failures++; $display("FAIL reload_first got=%0d:%h exp=%0d:%h", got_addr[w0], got_data[w0], exp_addr[0], exp_data[0]); end
    endtask

`ifdef DEBUG_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] b[$];
        int unsigned e0, d0, w0, p0;
        bit ok;
        bus.I_HALT = 1'b0;
        e0 = n_en; d0 = n_dump;
        fifo.push_back(CMD_CONT);
        wait_cnt(2, d0 + 1, ok);
        repeat (2) tick();
        exp_iter += 32'(TO_CYC);
        checks++; if (!ok) begin failures++; $display("FAIL to_dump_wait got=timeout exp=dump_req"); end
        checks++; if (n_en - e0 != TO_CYC) begin failures++; $display("FAIL to_en got=%0d exp=%0d", n_en - e0, TO_CYC); end
        checks++; if (bus.O_TIMEOUT !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", bus.O_TIMEOUT); end
        checks++; if (n_dump - d0 != 1) begin failures++; $display("FAIL to_dumps got=%0d exp=1", n_dump - d0); end
        pulse_done();
        b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        do_load(b, w0, p0, ok);
        checks++; if (bus.O_TIMEOUT !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", bus.O_TIMEOUT); end
        checks++; if (bus.O_ITERACIONES !== exp_iter) begin failures++; $display("FAIL to_iter got=%0d exp=%0d", bus.O_ITERACIONES, exp_iter); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_load_random();
        test_cont();
        test_step();
        test_halted();
        test_load_max();
        test_reset_midload();
`ifdef DEBUG_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
